// File: rtl/rv_div_pkg.sv
// rv_div_pkg: shared op encodings, FSM states and default width for the divide unit
package rv_div_pkg;
   localparam int DIV_WIDTH = 32;
   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
endpackage

// File: rtl/twos_mag.sv
// twos_mag: combinational conditional two's-complement negate
module twos_mag #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] val,
   input  logic             neg_en,
   output logic [WIDTH-1:0] out
);
   assign out = neg_en ? -val : val;
endmodule

// File: rtl/iter_div_unit.sv
// iter_div_unit: multi-cycle RV32M DIV/DIVU/REM/REMU, radix-2 restoring loop with sign fix-up
module iter_div_unit
   import rv_div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] num1,
   input  logic [WIDTH-1:0] num2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);
   localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
   state_t           r_state;
   logic             r_busy, r_done, r_rem_sel, r_qneg, r_rneg;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_q, r_rem, r_div, r_result;
   logic [WIDTH-1:0] w_m1, w_m2, w_spec, w_fix;
   logic [WIDTH:0]   w_sh, w_diff;
   logic             w_signed, w_zero, w_ovf, w_sp, w_accept;

   assign w_signed = ~op[0];
   assign w_zero   = num2 == '0;
   assign w_ovf    = w_signed && num1 == MIN && &num2;
   assign w_sp     = w_zero || w_ovf;
   assign w_accept = start && (r_state == IDLE || r_state == DONE);
   assign w_spec   = op[1] ? (w_zero ? num1 : '0) : (w_zero ? '1 : MIN);
   // remainder stays below the divisor, so the WIDTH+1 bit difference never overflows its sign
   assign w_sh     = {r_rem, r_q[WIDTH-1]};
   assign w_diff   = w_sh - {1'b0, r_div};

   twos_mag #(.WIDTH(WIDTH)) u_mag1 (.val(num1), .neg_en(w_signed & num1[WIDTH-1]), .out(w_m1));
   twos_mag #(.WIDTH(WIDTH)) u_mag2 (.val(num2), .neg_en(w_signed & num2[WIDTH-1]), .out(w_m2));
   twos_mag #(.WIDTH(WIDTH)) u_fix (
      .val(r_rem_sel ? r_rem : r_q),
      .neg_en(r_rem_sel ? r_rneg : r_qneg),
      .out(w_fix)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_rem_sel <= 1'b0;
         r_qneg    <= 1'b0;
         r_rneg    <= 1'b0;
         r_cnt     <= '0;
         r_q       <= '0;
         r_rem     <= '0;
         r_div     <= '0;
         r_result  <= '0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_rem_sel <= op[1];
            r_qneg    <= w_signed & (num1[WIDTH-1] ^ num2[WIDTH-1]);
            r_rneg    <= w_signed & num1[WIDTH-1];
            r_q       <= w_m1;
            r_div     <= w_m2;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_state   <= w_sp ? DONE : CALC;
            r_busy    <= !w_sp;
            r_done    <= w_sp;
            if (w_sp) r_result <= w_spec;
         end else if (r_state == CALC) begin
            r_rem <= w_diff[WIDTH] ? w_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], ~w_diff[WIDTH]};
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(WIDTH-1)) r_state <= FIX;
         end else if (r_state == FIX) begin
            r_result <= w_fix;
            r_state  <= DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
         end else begin
            r_state <= IDLE;
         end
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;
endmodule
